// File: rtl/alu_iterative_divider_if.sv
// ============================================================================
// Module      : alu_iterative_divider_if
// Description : Start/busy/done request and result bundle for the iterative
//               divider. Optional macro: SIGNED_DIV_EN (adds signed_op).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_iterative_divider_if #(
  parameter int BITS = 32
);
  logic            start;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic [BITS-1:0] Q;
  logic [BITS-1:0] R;
  logic            div_by_zero;
  logic            busy;
  logic            done;
`ifdef SIGNED_DIV_EN
  logic            signed_op;
`endif

  modport master (
`ifdef SIGNED_DIV_EN
    output signed_op,
`endif
    output start, A, B,
    input  Q, R, div_by_zero, busy, done
  );

  modport slave (
`ifdef SIGNED_DIV_EN
    input  signed_op,
`endif
    input  start, A, B,
    output Q, R, div_by_zero, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/alu_iterative_divider.sv
// ============================================================================
// Module      : alu_iterative_divider
// Description : Restoring shift-subtract divider, one quotient bit per clock.
//               Optional macro: SIGNED_DIV_EN (two's complement, truncating).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iterative_divider #(
  parameter int BITS = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  alu_iterative_divider_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = $clog2(BITS + 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic [BITS-1:0] dvd_q, dvd_d;
  logic [BITS-1:0] dvs_q, dvs_d;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS-1:0] r_q, r_d;
  logic            dbz_q, dbz_d;

  logic [BITS:0]   shifted;
  logic [BITS:0]   diff;
  logic            borrow;
  logic [BITS-1:0] q_step;
  logic [BITS-1:0] r_step;
  logic [BITS-1:0] q_fin;
  logic [BITS-1:0] r_fin;
  logic [BITS-1:0] a_mag;
  logic [BITS-1:0] b_mag;

`ifdef SIGNED_DIV_EN
  logic a_neg, b_neg;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign a_neg = bus.signed_op & bus.A[BITS-1];
  assign b_neg = bus.signed_op & bus.B[BITS-1];
  assign a_mag = a_neg ? (~bus.A + 1'b1) : bus.A;
  assign b_mag = b_neg ? (~bus.B + 1'b1) : bus.B;
  // Sign fix-up happens on the final iteration so DONE timing is unchanged.
  assign q_fin = qneg_q ? (~q_step + 1'b1) : q_step;
  assign r_fin = rneg_q ? (~r_step + 1'b1) : r_step;
`else
  assign a_mag = bus.A;
  assign b_mag = bus.B;
  assign q_fin = q_step;
  assign r_fin = r_step;
`endif

  // The restored remainder is always below the divisor, so only the trial
  // difference needs the extra bit.
  always_comb begin
    shifted = {rem_q, dvd_q[BITS-1]};
    diff    = shifted - {1'b0, dvs_q};
    borrow  = diff[BITS];
    q_step  = {dvd_q[BITS-2:0], ~borrow};
    r_step  = borrow ? shifted[BITS-1:0] : diff[BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d = '0;
          dvd_d = a_mag;
          dvs_d = b_mag;
          cnt_d = CW'(BITS);
          dbz_d = 1'b0;
`ifdef SIGNED_DIV_EN
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
`endif
          if (bus.B == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = bus.A;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = r_step;
        dvd_d = q_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          q_d     = q_fin;
          r_d     = r_fin;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.Q           = q_q;
  assign bus.R           = r_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_iterative_divider.sv
// ============================================================================
// Module      : tb_alu_iterative_divider
// Description : Scoreboard bench for alu_iterative_divider, directed + random.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_iterative_divider;

  localparam int BITS = 32;

  typedef struct {
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            dbz;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_iterative_divider_if #(.BITS(BITS)) bus ();

  alu_iterative_divider #(.BITS(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain arithmetic on the operand values.
  function automatic exp_t model(logic [BITS-1:0] a, logic [BITS-1:0] b,
                                 logic sop, int issue_cyc);
    exp_t e;
    logic [BITS-1:0] most_neg;
    most_neg = {1'b1, {(BITS-1){1'b0}}};
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.cyc = issue_cyc + 1;
    end else begin
      e.dbz = 1'b0;
      e.cyc = issue_cyc + 1 + BITS;
      if (sop) begin
        if (a == most_neg && b == '1) begin
          e.q = most_neg; e.r = '0;
        end else begin
          e.q = $signed(a) / $signed(b);
          e.r = $signed(a) % $signed(b);
        end
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient",    64'(bus.Q),           64'(mon_e.q));
        check("remainder",   64'(bus.R),           64'(mon_e.r));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
        check("done_cycle",  64'(cyc),             64'(mon_e.cyc));
      end
    end
  end

  // Called just after a falling edge; returns one falling edge later.
  task automatic issue(logic [BITS-1:0] a, logic [BITS-1:0] b, logic sop, bit accept);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
`ifdef SIGNED_DIV_EN
    bus.signed_op = sop;
`endif
    if (accept) sb.push_back(model(a, b, sop, cyc));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int dc;
    logic [BITS-1:0] a, b;
    logic sop;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
`ifdef SIGNED_DIV_EN
    bus.signed_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_Q",    64'(bus.Q),           64'd0);
    check("reset_R",    64'(bus.R),           64'd0);
    check("reset_dbz",  64'(bus.div_by_zero), 64'd0);
    check("reset_busy", 64'(bus.busy),        64'd0);
    check("reset_done", 64'(bus.done),        64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100/7 with busy window over the RUN cycles
    issue(100, 7, 1'b0, 1'b1);
    bad = 0;
    for (int k = 0; k < BITS; k++) begin
      if (!bus.busy || bus.done) bad++;
      @(negedge clk);
    end
    check("busy_window_run", 64'(bad), 64'd0);
    check("busy_in_done",    64'(bus.busy), 64'd1);
    @(negedge clk);
    check("idle_after_done", 64'(bus.busy), 64'd0);

    issue('1, 1, 1'b0, 1'b1);
    wait_idle();
    issue(5, 32'h8000_0000, 1'b0, 1'b1);
    wait_idle();
    issue(5, 0, 1'b0, 1'b1);
    wait_idle();
    issue(9, 3, 1'b0, 1'b1);
    wait_idle();
    issue(0, 9, 1'b0, 1'b1);
    wait_idle();
    issue(77, 77, 1'b0, 1'b1);
    wait_idle();

    // Starts while busy and in the DONE cycle are dropped
    issue(100, 7, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    issue(50, 5, 1'b0, 1'b0);
    wait_done();
    issue(50, 5, 1'b0, 1'b0);
    issue(50, 5, 1'b0, 1'b1);
    wait_idle();

    // Reset abandons an operation in flight
    issue(100, 7, 1'b0, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrun_rst_busy", 64'(bus.busy), 64'd0);
    check("midrun_rst_done", 64'(bus.done), 64'd0);
    check("midrun_rst_Q",    64'(bus.Q),    64'd0);
    check("midrun_rst_R",    64'(bus.R),    64'd0);
    rst = 1'b0;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 64'(done_cnt - dc), 64'd0);

`ifdef SIGNED_DIV_EN
    issue(32'hFFFF_FFF9, 2, 1'b1, 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();
    issue(32'hFFFF_FFF9, 0, 1'b1, 1'b1);
    wait_idle();
`endif

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = '0;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = BITS'($urandom_range(1, 15));
        2:       b = a;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      sop = 1'b0;
`ifdef SIGNED_DIV_EN
      sop = 1'($urandom_range(0, 1));
`endif
      issue(a, b, sop, 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_done: got no done, required result expected at cycle %0d", mon_e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
